clint_bus_bridge: RTL and testbench

//  Upstream adapter for the CLINT. Converts the core's 32-bit valid/ready data-bus request/response

---
 rtl/clint_bus_bridge_pkg.sv | 31 +++
 rtl/clint_strb_decode.sv | 41 ++++
 rtl/clint_bus_bridge.sv | 189 ++++++++++++++++++
 tb/tb_clint_bus_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_bus_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clint_bus_bridge_pkg                                                       |
// | Shared CLINT offsets, size encodings and bridge FSM states.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package clint_bus_bridge_pkg;

  localparam logic [15:0] c_mtimecmp_base = 16'h4000;
  localparam logic [15:0] c_mtime_addr    = 16'hBFF8;
  localparam logic [15:0] c_mtime_hi_addr = 16'hBFFC;

  localparam logic [2:0] c_size_b = 3'd0;
  localparam logic [2:0] c_size_h = 3'd1;
  localparam logic [2:0] c_size_w = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ERR     = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // 64-bit registers live from the mtimecmp block upward; their odd words sit in the upper half.
  function automatic logic upper_half_sel(input logic [15:0] offset);
    return (offset >= c_mtimecmp_base) && offset[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/clint_strb_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clint_strb_decode                                                          |
// | Maps byte strobes and address low bits to CLINT size, lane and legality.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clint_strb_decode
  import clint_bus_bridge_pkg::*;
(
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [3:0] wstrb,
  output logic [2:0] size,
  output logic [1:0] lane,
  output logic       legal
);

  logic w_known;

  always_comb begin
    size    = c_size_w;
    lane    = 2'd0;
    w_known = 1'b1;
    if (we) begin
      case (wstrb)
        4'b0001: begin size = c_size_b; lane = 2'd0; end
        4'b0010: begin size = c_size_b; lane = 2'd1; end
        4'b0100: begin size = c_size_b; lane = 2'd2; end
        4'b1000: begin size = c_size_b; lane = 2'd3; end
        4'b0011: begin size = c_size_h; lane = 2'd0; end
        4'b1100: begin size = c_size_h; lane = 2'd2; end
        4'b1111: begin size = c_size_w; lane = 2'd0; end
        default: w_known = 1'b0;
      endcase
    end
    // Reads decode to lane 0, so this also rejects misaligned reads.
    legal = w_known && (lane == addr);
  end

endmodule
`default_nettype wire

// File: rtl/clint_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clint_bus_bridge                                                           |
// | Core valid/ready bus to CLINT request adapter; optional coherent mtime     |
// | high-word snapshot under CLINT_MTIME_SNAPSHOT_EN.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clint_bus_bridge
  import clint_bus_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [31:0] s_req_addr,
  input  logic        s_req_we,
  input  logic [31:0] s_req_wdata,
  input  logic [3:0]  s_req_wstrb,
  output logic        s_rsp_valid,
  input  logic        s_rsp_ready,
  output logic [31:0] s_rsp_rdata,
  output logic        s_rsp_err,
  output logic        c_req_valid,
  output logic [15:0] c_req_addr,
  output logic [63:0] c_req_wdata,
  output logic        c_req_we,
  output logic [2:0]  c_req_size,
  input  logic        c_req_ready,
  input  logic [63:0] c_req_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic [1:0]  r_lane;

  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [2:0]  w_size;
  logic [1:0]  w_lane;
  logic        w_legal;
  logic        w_range_ok;
  logic        w_req_ok;
  logic        w_accept;
  logic        w_wr_done;
  logic        w_rsp_done;
  logic [31:0] w_live_word;
  logic [31:0] w_rd_word;

  clint_strb_decode u_strb_decode (
    .we    (s_req_we),
    .addr  (s_req_addr[1:0]),
    .wstrb (s_req_wstrb),
    .size  (w_size),
    .lane  (w_lane),
    .legal (w_legal)
  );

  assign w_range_ok = !CHECK_RANGE || (s_req_addr[31:16] == BASE_ADDR[31:16]);
  assign w_req_ok   = w_legal && w_range_ok;
  assign w_accept   = s_req_valid && s_req_ready;
  assign w_wr_done  = (r_state == ST_ISSUE) && c_req_ready && r_we;
  assign w_rsp_done = ((r_state == ST_ERR) || (r_state == ST_RESP)) && s_rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The error response is loaded at accept, so ERR already presents it and may complete directly.
  always_comb begin
    w_state_nxt = r_state;
    s_req_ready = 1'b0;
    c_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_req_ready = 1'b1;
        if (s_req_valid) begin
          w_state_nxt = w_req_ok ? ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        c_req_valid = 1'b1;
        if (c_req_ready) begin
          w_state_nxt = r_we ? ST_RESP : ST_CAPTURE;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_ERR:     w_state_nxt = s_rsp_ready ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        if (s_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_size  <= '0;
      r_lane  <= '0;
    end else if (w_accept) begin
      r_addr  <= s_req_addr[15:0];
      r_we    <= s_req_we;
      r_wdata <= s_req_wdata;
      r_size  <= w_size;
      r_lane  <= w_lane;
    end
  end

  assign c_req_addr  = r_addr;
  assign c_req_we    = r_we;
  assign c_req_size  = r_size;
  assign c_req_wdata = {32'h0, r_wdata >> {r_lane, 3'b000}};

  assign w_live_word = upper_half_sel(r_addr) ? c_req_rdata[63:32] : c_req_rdata[31:0];

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic        r_snap_valid;
  logic [31:0] r_snap;

  assign w_rd_word = ((r_addr == c_mtime_hi_addr) && r_snap_valid) ? r_snap : w_live_word;

  // Latching mtime's high word on the low-word read lets RV32 software read a coherent pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_valid <= 1'b0;
      r_snap       <= '0;
    end else if (r_state == ST_CAPTURE) begin
      if (r_addr == c_mtime_addr) begin
        r_snap       <= c_req_rdata[63:32];
        r_snap_valid <= 1'b1;
      end else if (r_addr == c_mtime_hi_addr) begin
        r_snap_valid <= 1'b0;
      end
    end else if (w_wr_done && (r_addr[15:3] == c_mtime_addr[15:3])) begin
      r_snap_valid <= 1'b0;
    end
  end
`else
  assign w_rd_word = w_live_word;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept && !w_req_ok) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= 1'b1;
      r_rsp_rdata <= '0;
    end else if (w_wr_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= w_rd_word;
    end else if (w_rsp_done) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end
  end

  assign s_rsp_valid = r_rsp_valid;
  assign s_rsp_err   = r_rsp_err;
  assign s_rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_clint_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clint_bus_bridge                                                        |
// | Bridge paired with a behavioural two-hart CLINT; directed and random txns. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_clint_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [31:0] s_req_addr = '0;
  logic        s_req_we = 1'b0;
  logic [31:0] s_req_wdata = '0;
  logic [3:0]  s_req_wstrb = '0;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b0;
  logic [31:0] s_rsp_rdata;
  logic        s_rsp_err;
  logic        c_req_valid;
  logic [15:0] c_req_addr;
  logic [63:0] c_req_wdata;
  logic        c_req_we;
  logic [2:0]  c_req_size;
  logic        c_req_ready = 1'b0;
  logic [63:0] c_req_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;

  clint_bus_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_addr  (s_req_addr),
    .s_req_we    (s_req_we),
    .s_req_wdata (s_req_wdata),
    .s_req_wstrb (s_req_wstrb),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_ready (s_rsp_ready),
    .s_rsp_rdata (s_rsp_rdata),
    .s_rsp_err   (s_rsp_err),
    .c_req_valid (c_req_valid),
    .c_req_addr  (c_req_addr),
    .c_req_wdata (c_req_wdata),
    .c_req_we    (c_req_we),
    .c_req_size  (c_req_size),
    .c_req_ready (c_req_ready),
    .c_req_rdata (c_req_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural CLINT: msip words at 0x0/0x4, mtimecmp at 0x4000/0x4008, mtime at 0xBFF8.
  logic [1:0]  m_msip = '0;
  logic [63:0] m_cmp [2] = '{64'h0, 64'h0};
  logic [63:0] m_mtime = '0;
  int          hs_count = 0;
  int          vld_count = 0;
  logic [15:0] mon_addr = '0;
  logic        mon_we = 1'b0;
  logic [2:0]  mon_size = '0;
  logic [63:0] mon_wdata = '0;

  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [2:0] boff,
                                          input logic [2:0] size, input logic [63:0] data);
    logic [63:0] r;
    int nb;
    r  = old;
    nb = 1 << size;
    for (int i = 0; i < nb; i++) begin
      if (int'(boff) + i < 8) r[8*(int'(boff)+i) +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] clint_read(input logic [15:0] a);
    if (a < 16'h4000) return {63'h0, m_msip[a[2]]};
    if (a[15:4] == 12'h400) return m_cmp[a[3]];
    if (a[15:3] == 13'h17FF) return m_mtime;
    return 64'h0;
  endfunction

  always @(posedge clk) begin
    m_mtime <= m_mtime + 64'd1;
    if (c_req_valid) vld_count <= vld_count + 1;
    if (c_req_valid && c_req_ready) begin
      hs_count  <= hs_count + 1;
      mon_addr  <= c_req_addr;
      mon_we    <= c_req_we;
      mon_size  <= c_req_size;
      mon_wdata <= c_req_wdata;
      if (c_req_we) begin
        if (c_req_addr < 16'h4000) begin
          if (c_req_addr[1:0] == 2'd0) m_msip[c_req_addr[2]] <= c_req_wdata[0];
        end else if (c_req_addr[15:4] == 12'h400) begin
          m_cmp[c_req_addr[3]] <= merge64(m_cmp[c_req_addr[3]], c_req_addr[2:0], c_req_size, c_req_wdata);
        end else if (c_req_addr[15:3] == 13'h17FF) begin
          m_mtime <= merge64(m_mtime, c_req_addr[2:0], c_req_size, c_req_wdata);
        end
      end else begin
        c_req_rdata <= clint_read(c_req_addr);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       c_req_ready = 1'b1;
        1:       c_req_ready = ($urandom_range(0, 2) != 0);
        default: c_req_ready = 1'b0;
      endcase
    end
  end

  // Core-visible reference: what each legal access should do to the register file.
  logic       ref_msip [2];
  logic [7:0] ref_cmp [16];

  function automatic logic ref_legal(input logic we, input logic [1:0] lo, input logic [3:0] st);
    int cnt;
    int first;
    int mask;
    if (!we) return lo == 2'd0;
    cnt   = $countones(st);
    first = 0;
    for (int i = 3; i >= 0; i--) if (st[i]) first = i;
    if (!(cnt == 1 || cnt == 2 || cnt == 4)) return 1'b0;
    mask = ((1 << cnt) - 1) << first;
    if (mask != int'(st)) return 1'b0;
    return (first == int'(lo)) && ((first % cnt) == 0);
  endfunction

  function automatic logic [2:0] ref_size(input logic we, input logic [3:0] st);
    if (!we) return 3'd2;
    case ($countones(st))
      1:       return 3'd0;
      2:       return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int rsp_delay,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic        exp_err;
    logic [15:0] off;
    logic [31:0] exp_rd;
    logic        known;
    logic [31:0] first_rd;
    logic        first_err;
    int          hs0;
    int          v0;
    int          n;
    int          base;
    off     = addr[15:0];
    exp_err = !ref_legal(we, addr[1:0], wstrb) || (addr[31:16] != 16'h0200);
    @(negedge clk);
    s_req_valid = 1'b1;
    s_req_addr  = addr;
    s_req_we    = we;
    s_req_wdata = wdata;
    s_req_wstrb = wstrb;
    n = 0;
    while (!s_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_req_ready) check_value("req_ready_timeout", 128'(s_req_ready), 128'd1);
    hs0 = hs_count;
    v0  = vld_count;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s_rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_value("rsp_valid_seen", 128'(s_rsp_valid), 128'd1);
    first_rd  = s_rsp_rdata;
    first_err = s_rsp_err;
    repeat (rsp_delay) @(negedge clk);
    if (rsp_delay > 0)
      check_value("rsp_stable", {s_rsp_valid, s_rsp_err, s_rsp_rdata}, {1'b1, first_err, first_rd});
    rdata = s_rsp_rdata;
    err   = s_rsp_err;
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    check_value("rsp_dropped", 128'(s_rsp_valid), 128'd0);
    check_value("err", 128'(err), 128'(exp_err));
    check_value("c_req_handshakes", 128'(hs_count - hs0), exp_err ? 128'd0 : 128'd1);
    if (exp_err) begin
      check_value("err_no_c_req_valid", 128'(vld_count - v0), 128'd0);
      check_value("err_rdata", 128'(rdata), 128'd0);
    end else begin
      check_value("c_req_fields", {mon_addr, mon_we, mon_size}, {off, we, ref_size(we, wstrb)});
      if (we) begin
        check_value("c_req_wdata", 128'(mon_wdata), 128'({32'h0, wdata >> (8 * int'(addr[1:0]))}));
        check_value("wr_rdata", 128'(rdata), 128'd0);
        if (off < 16'h0008 && wstrb[0]) ref_msip[off[2]] = wdata[0];
        if (off[15:4] == 12'h400) begin
          base = 4 * int'(off[3:2]);
          for (int i = 0; i < 4; i++) if (wstrb[i]) ref_cmp[base + i] = wdata[8*i +: 8];
        end
      end else begin
        known = 1'b0;
        exp_rd = '0;
        if (off < 16'h0008) begin
          known = 1'b1;
          exp_rd = {31'h0, ref_msip[off[2]]};
        end else if (off[15:4] == 12'h400) begin
          known = 1'b1;
          base = 4 * int'(off[3:2]);
          exp_rd = {ref_cmp[base+3], ref_cmp[base+2], ref_cmp[base+1], ref_cmp[base]};
        end
        if (known) check_value("rd_data", 128'(rdata), 128'(exp_rd));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [15:0] offs [6] = '{16'h0000, 16'h0004, 16'h4000, 16'h4004, 16'h4008, 16'h400C};
  logic [3:0]  strb_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  initial begin
    logic [31:0] r32;
    logic [31:0] a;
    logic [3:0]  st;
    logic [1:0]  lo;
    logic [15:0] hi;
    logic        we;
    logic [31:0] exp_hi;

    ref_msip[0] = 1'b0;
    ref_msip[1] = 1'b0;
    for (int i = 0; i < 16; i++) ref_cmp[i] = 8'h0;

    repeat (3) @(negedge clk);
    check_value("rst_s_req_ready", 128'(s_req_ready), 128'd1);
    check_value("rst_outputs",
                128'({s_rsp_valid, s_rsp_err, s_rsp_rdata, c_req_valid, c_req_addr, c_req_we, c_req_size, c_req_wdata}),
                128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // mtimecmp[0] = 0x1000 via two word writes
    ready_mode = 0;
    do_txn(32'h0200_4000, 1'b1, 32'h0000_1000, 4'b1111, 0, rd, er, lat);
    check_value("wr_latency", 128'(lat), 128'd2);
    do_txn(32'h0200_4004, 1'b1, 32'h0000_0000, 4'b1111, 0, rd, er, lat);
    check_value("mtimecmp0", 128'(m_cmp[0]), 128'h1000);

    // msip[1] by byte write, then read back with latency
    do_txn(32'h0200_0004, 1'b1, 32'h0000_0001, 4'b0001, 0, rd, er, lat);
    check_value("msip", 128'(m_msip), 128'b10);
    do_txn(32'h0200_0004, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("msip_read", 128'(rd), 128'd1);
    check_value("rd_latency", 128'(lat), 128'd3);

    // half write into mtimecmp[1][31:16]
    do_txn(32'h0200_400A, 1'b1, 32'hBEEF_0000, 4'b1100, 0, rd, er, lat);
    check_value("half_size_wdata", {mon_size, mon_wdata}, {3'd1, 64'h0000_0000_0000_BEEF});
    check_value("mtimecmp1_hi_half", 128'(m_cmp[1][31:16]), 128'hBEEF);

    // error cases: misaligned read, bad strobe, out of window
    do_txn(32'h0200_0002, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("err_latency_misalign", 128'(lat), 128'd1);
    do_txn(32'h0200_4000, 1'b1, 32'h1234_5678, 4'b0110, 0, rd, er, lat);
    check_value("err_latency_strobe", 128'(lat), 128'd1);
    do_txn(32'h0300_0000, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("err_latency_range", 128'(lat), 128'd1);
    do_txn(32'h0200_0000, 1'b1, 32'h0, 4'b0000, 0, rd, er, lat);

    // randomized traffic against the reference
    for (int t = 0; t < 80; t++) begin
      ready_mode = int'($urandom_range(0, 1));
      r32 = $urandom;
      we  = r32[0];
      if (r32[1]) begin
        st = strb_tab[$urandom_range(0, 6)];
        lo = 2'd0;
        for (int i = 3; i >= 0; i--) if (st[i]) lo = 2'(i);
      end else begin
        st = r32[5:2];
        lo = r32[7:6] & {2{r32[8]}};
      end
      if (!we) begin
        st = r32[12:9];
        if (r32[13]) lo = 2'd0;
      end
      hi = (r32[16:14] == 3'd0) ? (16'h0300 | {8'h0, r32[24:17]}) : 16'h0200;
      a  = {hi, offs[$urandom_range(0, 5)] | {14'h0, lo}};
      do_txn(a, we, $urandom, st, int'($urandom_range(0, 3)), rd, er, lat);
    end

    // mtime snapshot coherence
    ready_mode = 0;
`ifdef CLINT_MTIME_SNAPSHOT_EN
    exp_hi = 32'h1;
`else
    exp_hi = 32'h2;
`endif
    do_txn(32'h0200_BFFC, 1'b1, 32'h0000_0001, 4'b1111, 0, rd, er, lat);
    do_txn(32'h0200_BFF8, 1'b1, 32'hFFFF_FFF0, 4'b1111, 0, rd, er, lat);
    do_txn(32'h0200_BFF8, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("mtime_lo_near_wrap", 128'(rd[31:8]), 128'hFF_FFFF);
    repeat (40) @(negedge clk);
    do_txn(32'h0200_BFFC, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("mtime_hi", 128'(rd), 128'(exp_hi));

    // stalled response, then reset in the middle of ISSUE
    do_txn(32'h0200_4008, 1'b0, 32'h0, 4'b0000, 5, rd, er, lat);
    ready_mode = 2;
    @(negedge clk);
    s_req_valid = 1'b1;
    s_req_addr  = 32'h0200_0000;
    s_req_we    = 1'b0;
    s_req_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    check_value("mid_issue_c_req_valid", 128'(c_req_valid), 128'd1);
    reset_n = 1'b0;
    #1;
    check_value("abort_s_req_ready", 128'(s_req_ready), 128'd1);
    check_value("abort_outputs",
                128'({s_rsp_valid, s_rsp_err, s_rsp_rdata, c_req_valid, c_req_addr, c_req_we, c_req_size, c_req_wdata}),
                128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ready_mode = 0;
    do_txn(32'h0200_0004, 1'b0, 32'h0, 4'b0000, 0, rd, er, lat);
    check_value("post_reset_latency", 128'(lat), 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
